seven_seg_decoder: RTL and testbench



---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_lookup.sv | 29 ++
 rtl/seven_seg_decoder.sv | 61 ++++++
 tb/tb_seven_seg_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared segment-pattern constants and state type for the seven-segment decoder
package seg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  typedef enum logic {SETTLE, STABLE} state_t;
endpackage

// File: rtl/seg_lookup.sv
// seg_lookup: maps an active-low gfedcba pattern back to its digit
module seg_lookup
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       digit,
  output logic             hit,
  output logic             blank
);
  // table match; hit is cleared for anything that is not a legal digit
  always_comb begin
    digit = 4'd0;
    hit   = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: hit = 1'b0;
    endcase
  end
  assign blank = pattern == SEG_BLANK;
endmodule

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: deglitches a segment bus and decodes each new stable pattern to a digit
module seven_seg_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEG_W-1:0]     seg_in,
  output logic [3:0]           digit_out,
  output logic                 digit_valid,
  input  logic                 digit_ready,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 overrun,
  input  logic                 overrun_clr
);
  localparam logic [7:0] N = 8'(STABLE_CYCLES);
  logic [SEG_W-1:0] s_reg, last;
  logic [7:0]       cnt, cnt_nxt;
  state_t           state;
  logic [3:0]       lk_digit;
  logic             lk_hit, lk_blank, changed, accept, fresh, free, load, drop, bad;
  seg_lookup u_lookup (.pattern(seg_in), .digit(lk_digit), .hit(lk_hit), .blank(lk_blank));
  // acceptance happens once per run, on the edge the counter first reaches N
  always_comb begin
    changed = seg_in != s_reg;
    cnt_nxt = changed ? 8'd1 : (cnt == N) ? cnt : cnt + 8'd1;
    accept  = state == SETTLE && cnt_nxt == N;
    fresh   = accept && seg_in != last;
    free    = !digit_valid || digit_ready;
    load    = fresh && lk_hit && free;
    drop    = fresh && lk_hit && !free;
    bad     = fresh && !lk_hit && !lk_blank;
  end
  // sampler, FSM, output slot and error bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg       <= SEG_BLANK;
      cnt         <= 8'd0;
      state       <= SETTLE;
      last        <= SEG_BLANK;
      digit_out   <= 4'd0;
      digit_valid <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      overrun     <= 1'b0;
    end else begin
      s_reg       <= seg_in;
      cnt         <= cnt_nxt;
      state       <= accept ? STABLE : (state == STABLE && changed) ? SETTLE : state;
      last        <= fresh ? seg_in : last;
      digit_out   <= load ? lk_digit : digit_out;
      digit_valid <= load || (digit_valid && !digit_ready);
      err_pulse   <= bad;
      err_count   <= (bad && !(&err_count)) ? err_count + ERR_CNT_W'(1) : err_count;
      overrun     <= drop || (overrun && !overrun_clr);
    end
  end
endmodule

// File: tb/tb_seven_seg_decoder.sv
// tb_seven_seg_decoder: directed stimulus checked against a run-length behavioural model
module tb_seven_seg_decoder;
  localparam int N = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic [3:0] digit_out;
  logic       digit_valid, digit_ready = 1'b0, err_pulse, overrun, overrun_clr = 1'b0;
  logic [7:0] err_count;
  int n_cmp = 0, n_bad = 0, pulses = 0;
  logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
  logic [6:0] m_prev = 7'h7F, m_last = 7'h7F;
  int         m_run = 0, m_errc = 0;
  logic [3:0] m_digit = 4'd0;
  logic       m_valid = 1'b0, m_errp = 1'b0, m_ovr = 1'b0;

  seven_seg_decoder #(.STABLE_CYCLES(N), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit_out(digit_out), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .err_pulse(err_pulse), .err_count(err_count),
    .overrun(overrun), .overrun_clr(overrun_clr));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_digit(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  // model: a value is accepted when it has been seen on exactly N consecutive edges
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = 7'h7F; m_last = 7'h7F; m_run = 0; m_errc = 0;
      m_digit = 4'd0; m_valid = 1'b0; m_errp = 1'b0; m_ovr = 1'b0;
    end else begin
      automatic logic set = 1'b0;
      automatic int d;
      m_errp = 1'b0;
      m_run = (seg_in == m_prev) ? m_run + 1 : 1;
      m_prev = seg_in;
      if (m_valid && digit_ready) m_valid = 1'b0;
      if (m_run == N && seg_in != m_last) begin
        m_last = seg_in;
        d = find_digit(seg_in);
        if (d >= 0) begin
          if (!m_valid) begin m_valid = 1'b1; m_digit = 4'(d); end
          else set = 1'b1;
        end else if (seg_in != 7'h7F) begin
          m_errp = 1'b1;
          if (m_errc < 255) m_errc++;
        end
      end
      m_ovr = set || (m_ovr && !overrun_clr);
    end
  end

  // compare DUT against model every cycle, mid-period
  always @(negedge clk) if (!rst) begin
    check("valid", digit_valid, m_valid);
    check("digit", digit_out, m_digit);
    check("err_pulse", err_pulse, m_errp);
    check("err_count", err_count, m_errc);
    check("overrun", overrun, m_ovr);
    if (err_pulse) pulses++;
  end

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", digit_valid, 0);
    check("rst_digit", digit_out, 0);
    check("rst_errc", err_count, 0);
    hold(7'h7F, 10);
    check("blank_valid", digit_valid, 0);
    check("blank_ovr", overrun, 0);
    check("blank_errc", err_count, 0);
    digit_ready = 1'b1;
    hold(pats[3], 3);
    check("d3_early", digit_valid, 0);
    hold(pats[3], 1);
    check("d3_valid", digit_valid, 1);
    check("d3_digit", digit_out, 3);
    hold(pats[3], 1);
    check("d3_taken", digit_valid, 0);
    hold(pats[5], 2);
    hold(7'h7F, 1);
    hold(pats[5], 3);
    check("d5_early", digit_valid, 0);
    hold(pats[5], 1);
    check("d5_valid", digit_valid, 1);
    check("d5_digit", digit_out, 5);
    hold(pats[5], 2);
    check("d5_once", digit_valid, 0);
    digit_ready = 1'b0;
    hold(pats[1], 5);
    hold(pats[2], 5);
    check("ovr_digit", digit_out, 1);
    check("ovr_set", overrun, 1);
    overrun_clr = 1'b1;
    digit_ready = 1'b1;
    hold(pats[2], 1);
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    check("ovr_drain", digit_valid, 0);
    hold(pats[4], 4);
    check("d4_valid", digit_valid, 1);
    check("d4_digit", digit_out, 4);
    hold(pats[4], 1);
    p0 = pulses;
    for (int i = 0; i < 300; i++) begin
      hold(7'b1010101, 4);
      hold(7'h7F, 4);
    end
    check("err_sat", err_count, 255);
    check("err_pulses", pulses - p0, 300);
    digit_ready = 1'b0;
    hold(pats[7], 5);
    check("d7_valid", digit_valid, 1);
    seg_in = pats[8];
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", digit_valid, 0);
    check("arst_digit", digit_out, 0);
    check("arst_errc", err_count, 0);
    check("arst_ovr", overrun, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    hold(pats[7], 3);
    check("re7_early", digit_valid, 0);
    hold(pats[7], 1);
    check("re7_valid", digit_valid, 1);
    check("re7_digit", digit_out, 7);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
